// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the shared memory port and the arbiter.
// The arbiter uses the master view; the pipeline/memory environment uses the slave view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // instruction fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;
  // data access side
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;
  // memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              err;
  logic [CNT_W-1:0]  if_grants;
  logic [CNT_W-1:0]  dm_grants;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
    output if_ready, if_rdata, if_stall, dm_ready, dm_rdata, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err, if_grants, dm_grants
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
    input  if_ready, if_rdata, if_stall, dm_ready, dm_rdata, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err, if_grants, dm_grants
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and data access, with a bounded wait on the memory handshake.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        state_q, state_d;
  logic              last_dm_q, last_dm_d;   // last grant (and current owner): 1 = MEM, 0 = IF
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  if_cnt_q, if_cnt_d;
  logic [CNT_W-1:0]  dm_cnt_q, dm_cnt_d;

  // MEM wins unless IF also requests and MEM had the previous grant.
  logic              grant_dm;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] resp_data;
  logic              unused_sel_lsbs;

  assign grant_dm        = bus.dm_req && !(bus.if_req && last_dm_q);
  assign sel_addr        = grant_dm ? bus.dm_addr : bus.if_addr;
  assign unused_sel_lsbs = ^sel_addr[1:0];

  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    if_cnt_d    = if_cnt_q;
    dm_cnt_d    = dm_cnt_q;
    resp_data   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          state_d    = ST_BUSY;
          last_dm_d  = grant_dm;
          wait_d     = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = grant_dm && bus.dm_we;
          mem_addr_d = {sel_addr[ADDR_W-1:2], 2'b00};
          if (grant_dm) begin
            mem_wdata_d = bus.dm_wdata;
            if (dm_cnt_q != CNT_MAX) dm_cnt_d = dm_cnt_q + CNT_W'(1);
          end else begin
            if (if_cnt_q != CNT_MAX) if_cnt_d = if_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_BUSY: begin
        // A completing mem_ready wins over the timeout on the same edge.
        if (bus.mem_ready || wait_q == WAIT_LAST) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (bus.mem_ready) resp_data = bus.mem_rdata;
          else               err_d     = 1'b1;
          if (last_dm_q) begin
            dm_ready_d = 1'b1;
            dm_rdata_d = resp_data;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = resp_data;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_dm_q   <= 1'b0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
      if_cnt_q    <= '0;
      dm_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
      if_cnt_q    <= if_cnt_d;
      dm_cnt_q    <= dm_cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.err       = err_q;
  assign bus.if_grants = if_cnt_q;
  assign bus.dm_grants = dm_cnt_q;
  assign bus.if_stall  = bus.if_req & ~if_ready_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random pipeline/memory traffic against a transaction-timed reference model.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int NCYC    = 4000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a grant at edge g owns the port until mem_ready or edge g+TIMEOUT;
  // the ready pulse follows that edge and the next grant may happen two edges later.
  int          e;
  bit          m_act, m_own_dm, m_last_dm, m_err, m_if_rdy, m_dm_rdy, m_we;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd;
  int          m_g, m_earliest, m_ifc, m_dmc, ntx, lat;

  task automatic model_step();
    logic [31:0] d;
    m_if_rdy = 0;
    m_dm_rdy = 0;
    if (reset) begin
      m_act = 0; m_last_dm = 0; m_err = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_if_rd = 0; m_dm_rd = 0;
      m_ifc = 0; m_dmc = 0; m_earliest = e + 1;
      return;
    end
    if (m_act) begin
      if (bus.mem_ready || (e - m_g) == TIMEOUT) begin
        d = bus.mem_ready ? bus.mem_rdata : 32'h0;
        if (!bus.mem_ready) m_err = 1;
        if (m_own_dm) begin m_dm_rd = d; m_dm_rdy = 1; end
        else          begin m_if_rd = d; m_if_rdy = 1; end
        m_act = 0;
        m_earliest = e + 2;
      end
    end else if (e >= m_earliest && (bus.if_req || bus.dm_req)) begin
      m_own_dm  = bus.dm_req && !(bus.if_req && m_last_dm);
      m_last_dm = m_own_dm;
      m_act = 1;
      m_g = e;
      if (m_own_dm) begin
        m_we = bus.dm_we; m_addr = bus.dm_addr & ~32'h3; m_wdata = bus.dm_wdata;
        m_dmc = (m_dmc < CMAX) ? m_dmc + 1 : CMAX;
      end else begin
        m_we = 0; m_addr = bus.if_addr & ~32'h3;
        m_ifc = (m_ifc < CMAX) ? m_ifc + 1 : CMAX;
      end
    end
  endtask

  task automatic check_outputs();
    chk("mem_req",   bus.mem_req,   m_act);
    chk("mem_we",    bus.mem_we,    m_we);
    chk("mem_addr",  bus.mem_addr,  m_addr);
    if (m_act && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("if_ready",  bus.if_ready,  m_if_rdy);
    chk("dm_ready",  bus.dm_ready,  m_dm_rdy);
    chk("if_rdata",  bus.if_rdata,  m_if_rd);
    chk("dm_rdata",  bus.dm_rdata,  m_dm_rd);
    chk("err",       bus.err,       m_err);
    chk("if_grants", bus.if_grants, 64'(m_ifc));
    chk("dm_grants", bus.dm_grants, 64'(m_dmc));
  endtask

  task automatic drive_inputs();
    reset = (e < 2) || (e > 60 && $urandom_range(0, 399) == 0);
    // memory: per-transaction latency, directed for the first three accesses
    if (m_act && e == m_g) begin
      ntx++;
      case (ntx)
        1:       lat = 5;
        2:       lat = 0;
        3:       lat = TIMEOUT + 1;
        default: lat = $urandom_range(0, TIMEOUT + 1);
      endcase
    end
    bus.mem_ready = m_act ? ((e - m_g) == lat) : 1'($urandom_range(0, 1));
    bus.mem_rdata = (ntx == 2) ? 32'h8C01_0004 : $urandom;
    if (e == 2) begin
      bus.if_req = 1; bus.if_addr = 32'h0000_0042;
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF;
      return;
    end
    if (m_if_rdy) begin
      bus.if_req = 1'($urandom_range(0, 1));
      bus.if_addr = $urandom;
    end else if (bus.if_req && $urandom_range(0, 31) == 0) bus.if_req = 0;
    else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
      bus.if_req = 1; bus.if_addr = $urandom;
    end
    if (m_dm_rdy) begin
      bus.dm_req = 1'($urandom_range(0, 1));
      bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
    end else if (bus.dm_req && $urandom_range(0, 31) == 0) bus.dm_req = 0;
    else if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
      bus.dm_req = 1;
      bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
    end
  endtask

  initial begin
    e = 0; ntx = 0; lat = 0;
    m_act = 0; m_own_dm = 0; m_last_dm = 0; m_err = 0; m_if_rdy = 0; m_dm_rdy = 0; m_we = 0;
    m_addr = 0; m_wdata = 0; m_if_rd = 0; m_dm_rd = 0;
    m_g = 0; m_earliest = 0; m_ifc = 0; m_dmc = 0;
    reset = 1;
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    repeat (NCYC) begin
      @(posedge clk);
      #1;
      e++;
      model_step();
      check_outputs();
      drive_inputs();
      #1;
      chk("if_stall", bus.if_stall, bus.if_req & ~m_if_rdy);
      chk("dm_stall", bus.dm_stall, bus.dm_req & ~m_dm_rdy);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
